wb_uart_tx: RTL
===============

// Module: wb_uart_tx
// PURPOSE
// - Wishbone B4 classic slave (responder) on the J1 data bus: memory-mapped UART transmitter.
// - Core stores bytes into a TX FIFO; a serialiser shifts them out on txd, 8N1, LSB first.
// - Sits beside spram_wrapper on the core's data bus; bus decode drives cyc.
// PARAMETERS
// - FIFO_DEPTH  16   TX FIFO entries; power of two, >= 2.
// - DEFAULT_DIV 867  Reset value of DIVISOR. Bit period = DIVISOR+1 clk cycles; 867 gives 115200 baud at 100 MHz.
// PORTS
// - clk      in   1   system clock, rising edge
// - reset    in   1   synchronous, active-high reset
// - wb_cyc   in   1   bus cycle valid
// - wb_stb   in   1   strobe
// - wb_we    in   1   1 = write
// - wb_adr   in   2   word address: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved
// - wb_dat_i in  16   write data
// - wb_dat_o out 16   read data
// - wb_ack   out  1   transfer acknowledge
// - txd      out  1   serial output, idle high
// - irq      out  1   level: high while FIFO empty and serialiser idle
// BEHAVIOUR
// - Reset: wb_ack=0, wb_dat_o=0, txd=1, FIFO empty, DIVISOR=DEFAULT_DIV, overflow=0, FSM IDLE, irq=1.
// - Handshake: ack is registered, one wait state. wb_ack=1 exactly one cycle after a cycle where
//   cyc&stb&!wb_ack; cleared the following cycle. Side effects (push, register write, flag clear)
//   take place on that same edge, once per access.
// - Writes: TXDATA pushes wb_dat_i[7:0]. DIVISOR loads wb_dat_i[15:0]. STATUS and reserved: ignored.
// - Reads: TXDATA returns 0. STATUS = {12'b0, overflow, busy, empty, full}. DIVISOR returns value.
//   Reserved returns 0. wb_dat_o valid while wb_ack=1.
// - Full: TXDATA push while full is dropped, sets sticky overflow; FIFO contents unchanged.
//   A pop in the same cycle does not make room; push is judged on the pre-edge full flag.
// - Reading STATUS clears overflow after returning it. A new overflow on the same edge wins (stays 1).
// - FIFO: circular, pointers wrap modulo FIFO_DEPTH, extra bit on pointers separates full from empty.
// - FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE, or STOP -> START when FIFO non-empty.
//   IDLE: txd=1; on !empty pop head into shift reg, load baud counter, go START next edge.
//   START txd=0; DATA txd=shift[0], shift right each bit; STOP txd=1. Each state lasts DIVISOR+1 cycles.
//   Back-to-back frames: no idle gap between STOP and next START.
// - Baud counter loads DIVISOR at each bit start, counts down to 0. DIVISOR writes take effect at
//   the next bit boundary; a frame in flight keeps its current bit length.
// - busy = FSM != IDLE. txd driven from a flop (glitch-free).
// - Reset mid-frame: txd=1 on the next edge, FIFO flushed, pending frame lost.
// CONFIGURATION
// - UART_TX_PARITY_EN defined: PARITY state inserted after DATA, txd = even parity (XOR of 8 data
//   bits), frame 11 bits (8E1); STATUS[4] reads 1 to report the feature.
// - Undefined: no PARITY state, 8N1 frame of 10 bits, STATUS[4] reads 0.
// TESTING
// - Reset, read STATUS and DIVISOR -> 0x0002 and 867; txd=1; irq=1; each ack exactly 1 cycle after stb.
// - DIVISOR=3, write TXDATA 0x55 -> txd: 4 cycles 0, bits 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles 1;
//   frame 40 cycles (44 with UART_TX_PARITY_EN, parity bit 0).
// - DIVISOR=3, write 0x01,0x80 back-to-back -> two frames with no idle gap; STATUS busy=1 until 80th
//   cycle after start, then STATUS=0x0002, irq=1.
// - DIVISOR=100, write FIFO_DEPTH+2 bytes quickly -> full=1, overflow=1; first read STATUS shows 0x9
//   bit set, second read overflow=0; exactly FIFO_DEPTH+1 frames sent (1 popped early), byte order kept.
// - Assert reset in DATA bit 3 of a frame with 3 bytes queued -> txd=1 next cycle, STATUS=0x0002,
//   no further frames; DIVISOR back to 867.
// - Write DIVISOR=7 mid-frame at DIVISOR=3 -> current bit stays 4 cycles, following bits 8 cycles.

Source files
------------

// File: rtl/wb_uart_tx.sv
// Wishbone B4 classic memory-mapped UART transmitter: TX FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frame).
module wb_uart_tx #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [1:0]  wb_adr,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack,
    output logic        txd,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_BIT = 1'b1;
`else
    localparam logic PAR_BIT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t      state, state_n;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, busy, overflow;
    logic [15:0] divisor, cnt, rdata, status;
    logic [7:0]  shift, head;
    logic [2:0]  bit_idx;
    logic        access, wr_txdata, push, ovf_set, rd_status;
    logic        pop, load_cnt, shift_en, txd_n, bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity;
`endif

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign busy      = (state != S_IDLE);
    assign irq       = empty && !busy;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign bit_end   = (cnt == 16'd0);

    // Every side effect keys off the single cycle that precedes the registered ack.
    assign access    = wb_cyc && wb_stb && !wb_ack;
    assign wr_txdata = access && wb_we && (wb_adr == 2'd0);
    assign push      = wr_txdata && !full;
    assign ovf_set   = wr_txdata && full;
    assign rd_status = access && !wb_we && (wb_adr == 2'd1);
    assign status    = {11'b0, PAR_BIT, overflow, busy, empty, full};

    always_comb begin
        rdata = 16'h0000;
        case (wb_adr)
            2'd1:    rdata = status;
            2'd2:    rdata = divisor;
            default: rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= 16'h0000;
            divisor  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            wb_ack   <= access;
            wb_dat_o <= (access && !wb_we) ? rdata : 16'h0000;
            if (access && wb_we && (wb_adr == 2'd2))
                divisor <= wb_dat_i;
            if (ovf_set)
                overflow <= 1'b1;
            else if (rd_status)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // txd_n is the line level for the state being entered, so txd changes with the state register.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        load_cnt = 1'b0;
        shift_en = 1'b0;
        txd_n    = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    load_cnt = 1'b1;
                    state_n  = S_START;
                    txd_n    = 1'b0;
                end
            end
            S_START: begin
                txd_n = 1'b0;
                if (bit_end) begin
                    load_cnt = 1'b1;
                    state_n  = S_DATA;
                    txd_n    = shift[0];
                end
            end
            S_DATA: begin
                txd_n = shift[0];
                if (bit_end) begin
                    load_cnt = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        txd_n   = parity;
`else
                        state_n = S_STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        txd_n = shift[1];
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_TX_PARITY_EN
                txd_n = parity;
                if (bit_end) begin
                    load_cnt = 1'b1;
                    state_n  = S_STOP;
                    txd_n    = 1'b1;
                end
`else
                state_n = S_IDLE;
`endif
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        load_cnt = 1'b1;
                        state_n  = S_START;
                        txd_n    = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            cnt     <= 16'd0;
            shift   <= 8'h00;
            bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            txd   <= txd_n;
            if (load_cnt)
                cnt <= divisor;
            else if (cnt != 16'd0)
                cnt <= cnt - 16'd1;
            if (pop) begin
                shift   <= head;
                bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
                parity  <= ^head;
`endif
            end else if (shift_en) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end
endmodule
